dp_result_collector: RTL
========================

Name: dp_result_collector

Overview:
- Receive-side companion for the team's fixed-latency registered datapaths, e.g. the a/b/c -> x/z arithmetic circuits built from ADD/SUB/COMP/MUX2x1/REG/SHL/SHR.
- The datapaths have no handshake. This block issues credit-controlled input-valid tokens and tracks them through a LATENCY-deep valid pipeline.
- It captures the datapath x/z outputs on the matching cycle and buffers them in a small FIFO.
- The captured pairs are presented on a ready/valid output, so downstream backpressure never drops a result.

Parameters:
- DATAWIDTH, 32, width of each captured result (x and z).
- LATENCY, 2, cycles from an accepted input to a valid datapath output; must be >= 1.
- DEPTH, 4, FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  producer presents operands to the datapath this cycle.
- in_ready  output  1  collector has credit; the operand beat is accepted when in_valid & in_ready.
- dp_x  input  DATAWIDTH  datapath x output.
- dp_z  input  DATAWIDTH  datapath z output.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer takes the head this cycle.
- out_x  output  DATAWIDTH  head x.
- out_z  output  DATAWIDTH  head z.
- count  output  clog2(DEPTH)+1  FIFO occupancy.
- inflight  output  clog2(LATENCY)+1  accepted beats not yet captured.
- overflow  output  1  sticky error flag.

Behaviour:
- Reset (async, immediate): valid pipeline cleared, FIFO pointers=0, count=0, inflight=0, overflow=0, out_valid=0. out_x/out_z read 0 (memory cleared on reset).
- Accept = in_valid & in_ready.
- in_ready = (count + inflight < DEPTH), combinational from registers only. It must not depend on in_valid or out_ready.
- Valid pipeline: LATENCY-bit shift register. Bit0 <= accept each cycle. tail = bit[LATENCY-1].
- Push when tail=1: {dp_x, dp_z} written at wr_ptr on the same edge. This gives exactly LATENCY cycles from accept edge to capture edge.
- inflight = popcount of the pipeline. It is maintained as a counter: +1 on accept, -1 on tail, unchanged if both.
- Pop = out_valid & out_ready. rd_ptr advances. out_x/out_z are combinational from mem[rd_ptr] (first-word fall-through).
- out_valid = (count != 0).
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop at count=DEPTH: legal. Write the freed slot, count stays DEPTH.
- Push with count=DEPTH and no pop: unreachable under the credit rule. If it happens (misconfigured LATENCY), the data is dropped, FIFO unchanged, overflow<=1. overflow stays set until reset.
- Push at count=0 with out_ready=1: the data appears on out_x/out_z the cycle after the push edge, not combinationally the same cycle.
- Credit includes in-flight beats, so the FIFO can never be oversubscribed. Sustained throughput is 1 beat/cycle when out_ready=1 and DEPTH >= LATENCY+1.
- Reset mid-operation discards in-flight beats and FIFO contents. Datapath results arriving after reset are ignored because the pipeline was cleared.
- No combinational path from out_ready to in_ready.

Test Plan:
1. Reset then single beat: in_valid=1 for one cycle at T0, bench drives dp_x=0x11, dp_z=0x22 at T0+2, out_ready=1 -> out_valid=1 at T0+3 with out_x=0x11, out_z=0x22. count returns 0 after the pop. inflight is 1 during T0+1..T0+2.
2. Backpressure fill, out_ready=0, in_valid held high, DEPTH=4, LATENCY=2 -> exactly 4 accepts. in_ready drops after the 4th accept; count reaches 4; overflow stays 0.
3. Streaming: in_valid=1 and out_ready=1 for 20 cycles with dp_x=cycle index -> 20 results in order with no gaps after the initial latency, and count never exceeds 1.
4. Wrap-around: 10 beats with out_ready toggling 1/0 every cycle -> results appear in order, pointers wrap past index 3, and no data is lost or duplicated.
5. Full plus simultaneous push/pop: with count=3 and inflight=1, assert out_ready on the push cycle -> count stays 3 and the ordering is preserved.
6. Async reset asserted mid-stream with count=2 and inflight=2 -> out_valid, count and inflight drop to 0 immediately. Stale dp_x arriving 1 cycle after reset release is not captured.

Source files
------------

// File: rtl/dp_result_collector.sv
// dp_result_collector
//   Receive-side companion for a fixed-latency, handshake-free registered
//   datapath. Operand beats are admitted with credit (in_ready), tracked
//   through a LATENCY-deep valid shift register, and the datapath x/z outputs
//   are captured into a DEPTH-entry FIFO exactly LATENCY cycles after the
//   accepting edge. Results leave on a first-word-fall-through ready/valid port.
//
//   Parameters
//     DATAWIDTH  width of x and z
//     LATENCY    accept-to-valid-output cycles of the datapath (>= 1)
//     DEPTH      FIFO entries (power of 2, >= 2)
//
//   Ports
//     clk, rst            rising-edge clock, async active-high reset
//     in_valid/in_ready   operand beat handshake (in_ready from registers only)
//     dp_x, dp_z          datapath outputs, sampled when the tracked beat lands
//     out_valid/out_ready result handshake, out_x/out_z = FIFO head
//     count               FIFO occupancy
//     inflight            accepted beats not yet captured
//     overflow            sticky: a result arrived with the FIFO full and no pop
module dp_result_collector #(
  parameter int DATAWIDTH = 32,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATAWIDTH-1:0]         dp_x,
  input  logic [DATAWIDTH-1:0]         dp_z,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATAWIDTH-1:0]         out_x,
  output logic [DATAWIDTH-1:0]         out_z,
  output logic [$clog2(DEPTH):0]       count,
  output logic [$clog2(LATENCY):0]     inflight,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LATENCY) + 1;
  // one extra bit so count + inflight cannot wrap before the compare
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [LATENCY-1:0]                vld_pipe;
  logic [DEPTH-1:0][DATAWIDTH-1:0]   mem_x;
  logic [DEPTH-1:0][DATAWIDTH-1:0]   mem_z;
  logic [AW-1:0]                     wr_ptr;
  logic [AW-1:0]                     rd_ptr;

  logic accept;
  logic tail;
  logic pop;
  logic full;
  logic wr_en;
  logic [SW-1:0] committed;

  // Credit counts beats already in the datapath, so every accepted beat has
  // a FIFO slot reserved by the time it lands.
  assign committed = SW'(count) + SW'(inflight);
  assign in_ready  = (committed < SW'(DEPTH));

  assign accept    = in_valid & in_ready;
  assign tail      = vld_pipe[LATENCY-1];
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count == CW'(DEPTH));
  // When full, a concurrent pop frees the slot at wr_ptr (== rd_ptr) on this
  // same edge; the head is read combinationally before the write lands.
  assign wr_en     = tail & (~full | pop);

  assign out_x = mem_x[rd_ptr];
  assign out_z = mem_z[rd_ptr];

  // Valid tracking: bit0 takes this cycle's accept, the top bit marks the
  // cycle in which the datapath output belongs to a tracked beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      inflight <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | LATENCY'(accept);
      case ({accept, tail})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Result FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_x  <= '0;
      mem_z  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem_x[wr_ptr] <= dp_x;
        mem_z[wr_ptr] <= dp_z;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy and the sticky overflow flag. A dropped result can only come
  // from a LATENCY parameter that does not match the real datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (tail & ~wr_en)
        overflow <= 1'b1;
    end
  end

endmodule
